// File: rtl/nn_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_mem_pkg
//  Description : Default configuration constants and the bank/row address
//                decomposition helpers shared by the banked NN memory.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_mem_pkg;

    localparam int c_DEF_NUM_CH    = 21;     // 1 input + 10 weight + 10 bias streams
    localparam int c_DEF_DATA_W    = 32;
    localparam int c_DEF_DEPTH     = 32768;
    localparam int c_DEF_NUM_BANKS = 4;
    localparam int c_DEF_ADDR_W    = 16;

    // Low-order interleave: consecutive words land in consecutive banks.
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned num_banks);
        return addr % num_banks;
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned num_banks);
        return addr / num_banks;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nn_rr_arbiter
//  Description : Round-robin arbiter, NUM_CH requesters, at most one one-hot
//                grant per cycle. The pointer names the highest-priority
//                requester and advances to (granted + 1) mod NUM_CH.
//  Revision    : 1.0  initial release
// ============================================================================
module nn_rr_arbiter #(
    parameter int NUM_CH = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_gnt
);

    localparam int c_PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [c_PTR_W-1:0] w_idx;
    logic               w_found;

    // Scan requesters starting at the pointer, wrapping at NUM_CH; first hit wins.
    always_comb begin
        o_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = c_PTR_W'((int'(r_ptr) + i >= NUM_CH) ? (int'(r_ptr) + i - NUM_CH)
                                                         : (int'(r_ptr) + i));
            if (i_en && !w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_ptr_nxt    = (w_idx == c_PTR_W'(NUM_CH - 1)) ? '0 : w_idx + c_PTR_W'(1);
            end
        end
    end

    // Pointer only moves on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nn_banked_mem.sv
`default_nettype none
// ============================================================================
//  Module      : nn_banked_mem
//  Description : Multi-channel banked word memory. NUM_BANKS low-order
//                interleaved single-read-port banks, one round-robin arbiter
//                per bank, one write port that always wins its bank.
//                Read data arrives one cycle after grant and is held per
//                channel until that channel's next valid.
//                Optional feature macro: NN_MEM_PARITY_EN (even parity bit
//                stored per word, checked on read).
//  Revision    : 1.0  initial release
// ============================================================================
module nn_banked_mem
    import nn_mem_pkg::*;
#(
    parameter int NUM_CH    = c_DEF_NUM_CH,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int NUM_BANKS = c_DEF_NUM_BANKS,
    parameter int ADDR_W    = c_DEF_ADDR_W
) (
    input  logic                     clock_mem,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_CH-1:0]        rd_req,
    input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
    output logic [NUM_CH-1:0]        rd_gnt,
    output logic [NUM_CH-1:0]        rd_valid,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0]        rd_err
);

    localparam int c_BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int c_ROWS   = DEPTH / NUM_BANKS;
    localparam int c_ROW_W  = (c_ROWS > 1) ? $clog2(c_ROWS) : 1;
`ifdef NN_MEM_PARITY_EN
    localparam int c_MEM_W  = DATA_W + 1;
`else
    localparam int c_MEM_W  = DATA_W;
`endif

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0]   w_ch_addr [NUM_CH];
    logic [c_BANK_W-1:0] w_ch_bank [NUM_CH];
    logic [c_ROW_W-1:0]  w_ch_row  [NUM_CH];
    logic [NUM_CH-1:0]   w_ch_oor;

    logic                w_wr_oor;
    logic [c_BANK_W-1:0] w_wr_bank;
    logic [c_ROW_W-1:0]  w_wr_row;
    logic [c_MEM_W-1:0]  w_wr_word;

    // Split every channel address into bank/row and flag addresses past DEPTH.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_ch_addr[c] = rd_addr[c*ADDR_W +: ADDR_W];
            w_ch_oor[c]  = (32'(w_ch_addr[c]) >= 32'(DEPTH));
            w_ch_bank[c] = c_BANK_W'(bank_of(32'(w_ch_addr[c]), 32'(NUM_BANKS)));
            w_ch_row[c]  = c_ROW_W'(row_of(32'(w_ch_addr[c]), 32'(NUM_BANKS)));
        end
    end

    assign w_wr_oor  = (32'(wr_addr) >= 32'(DEPTH));
    assign w_wr_bank = c_BANK_W'(bank_of(32'(wr_addr), 32'(NUM_BANKS)));
    assign w_wr_row  = c_ROW_W'(row_of(32'(wr_addr), 32'(NUM_BANKS)));

`ifdef NN_MEM_PARITY_EN
    assign w_wr_word = {^wr_data, wr_data};
`else
    assign w_wr_word = wr_data;
`endif

    // ---------------- banks ----------------
    logic [NUM_CH-1:0]  w_bank_gnt [NUM_BANKS];
    logic [c_MEM_W-1:0] w_bank_q   [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_CH-1:0]  w_req;
        logic [NUM_CH-1:0]  w_gnt;
        logic               w_wr_hit;
        logic               w_en;
        logic               w_rd_en;
        logic [c_ROW_W-1:0] w_rd_row;
        logic [c_MEM_W-1:0] r_mem [c_ROWS];
        logic [c_MEM_W-1:0] r_q;

        // An in-range write owns the bank this cycle; out-of-range writes take nothing.
        assign w_wr_hit = wr_en & ~w_wr_oor & (w_wr_bank == c_BANK_W'(b));
        assign w_en     = ~rst & ~w_wr_hit;

        // In-range requests that target this bank compete here.
        always_comb begin
            w_req = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                w_req[c] = rd_req[c] & ~w_ch_oor[c] & (w_ch_bank[c] == c_BANK_W'(b));
            end
        end

        nn_rr_arbiter #(
            .NUM_CH (NUM_CH)
        ) u_arb (
            .clk   (clock_mem),
            .rst   (rst),
            .i_en  (w_en),
            .i_req (w_req),
            .o_gnt (w_gnt)
        );

        // Grant is one-hot, so OR-ing the selected rows picks the winner's row.
        always_comb begin
            w_rd_row = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_gnt[c]) begin
                    w_rd_row = w_rd_row | w_ch_row[c];
                end
            end
        end

        assign w_rd_en = |w_gnt;

        // Write port; storage is never reset.
        always_ff @(posedge clock_mem) begin
            if (w_wr_hit) begin
                r_mem[w_wr_row] <= w_wr_word;
            end
        end

        // Registered read port, captured in the grant cycle.
        always_ff @(posedge clock_mem) begin
            if (w_rd_en) begin
                r_q <= r_mem[w_rd_row];
            end
        end

        assign w_bank_gnt[b] = w_gnt;
        assign w_bank_q[b]   = r_q;
    end

    // ---------------- grants ----------------
    logic [NUM_CH-1:0] w_rd_gnt;

    // Out-of-range requests are granted immediately without touching a bank.
    always_comb begin
        w_rd_gnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_rd_gnt[c] = rd_req[c] & w_ch_oor[c] & ~rst;
            for (int b = 0; b < NUM_BANKS; b++) begin
                w_rd_gnt[c] = w_rd_gnt[c] | w_bank_gnt[b][c];
            end
        end
    end

    assign rd_gnt = w_rd_gnt;

    // ---------------- response pipeline ----------------
    logic [NUM_CH-1:0]   r_valid;
    logic [NUM_CH-1:0]   r_oor;
    logic [c_BANK_W-1:0] r_src  [NUM_CH];
    logic [DATA_W-1:0]   r_hold [NUM_CH];
    logic [DATA_W-1:0]   w_out_data [NUM_CH];
    logic [c_MEM_W-1:0]  w_sel_q    [NUM_CH];
    logic [NUM_CH-1:0]   w_par_fail;

    // Valid/out-of-range tags and the held data word; reset drops in-flight reads.
    always_ff @(posedge clock_mem) begin
        if (rst) begin
            r_valid <= '0;
            r_oor   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_hold[c] <= '0;
            end
        end else begin
            r_valid <= w_rd_gnt;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_rd_gnt[c]) begin
                    r_oor[c] <= w_ch_oor[c];
                end
                r_hold[c] <= w_out_data[c];
            end
        end
    end

    // Remember which bank's read register serves each accepted read.
    always_ff @(posedge clock_mem) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_rd_gnt[c]) begin
                r_src[c] <= w_ch_bank[c];
            end
        end
    end

    // Steer bank read data to channels; outputs are forced quiet while rst is high.
    always_comb begin
        rd_data = '0;
        rd_err  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sel_q[c]    = w_bank_q[r_src[c]];
            w_out_data[c] = r_hold[c];
            if (r_valid[c]) begin
                w_out_data[c] = r_oor[c] ? '0 : w_sel_q[c][DATA_W-1:0];
            end
`ifdef NN_MEM_PARITY_EN
            w_par_fail[c] = ^w_sel_q[c];
`else
            w_par_fail[c] = 1'b0;
`endif
            rd_data[c*DATA_W +: DATA_W] = rst ? '0 : w_out_data[c];
            rd_err[c] = ~rst & r_valid[c] & (r_oor[c] | w_par_fail[c]);
        end
    end

    assign rd_valid = r_valid & {NUM_CH{~rst}};

endmodule
`default_nettype wire

// File: tb/tb_nn_banked_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nn_banked_mem
//  Description : Directed scoreboard bench for nn_banked_mem. Stimulus checks
//                grants and queues expected responses; a monitor pops and
//                compares whenever rd_valid appears, and checks data hold.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nn_banked_mem;

    localparam int c_NUM_CH = 21;
    localparam int c_DATA_W = 32;
    localparam int c_DEPTH  = 32768;
    localparam int c_BANKS  = 4;
    localparam int c_ADDR_W = 16;

    logic                         clock_mem;
    logic                         rst;
    logic                         wr_en;
    logic [c_ADDR_W-1:0]          wr_addr;
    logic [c_DATA_W-1:0]          wr_data;
    logic [c_NUM_CH-1:0]          rd_req;
    logic [c_NUM_CH*c_ADDR_W-1:0] rd_addr;
    logic [c_NUM_CH-1:0]          rd_gnt;
    logic [c_NUM_CH-1:0]          rd_valid;
    logic [c_NUM_CH*c_DATA_W-1:0] rd_data;
    logic [c_NUM_CH-1:0]          rd_err;

    nn_banked_mem #(
        .NUM_CH    (c_NUM_CH),
        .DATA_W    (c_DATA_W),
        .DEPTH     (c_DEPTH),
        .NUM_BANKS (c_BANKS),
        .ADDR_W    (c_ADDR_W)
    ) dut (
        .clock_mem (clock_mem),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err)
    );

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [int];
    logic [31:0] last_data [c_NUM_CH];
    int          parity_bad = -1;
    int          checks = 0;
    int          errors = 0;

    initial clock_mem = 1'b0;
    always #5 clock_mem = ~clock_mem;

    task automatic rd(input int ch, input int addr);
        rd_req[ch] = 1'b1;
        rd_addr[ch*c_ADDR_W +: c_ADDR_W] = c_ADDR_W'(addr);
    endtask

    // Inputs are set by the caller just after a negedge; check grant, queue
    // expected responses, update the model, and move to the next negedge.
    task automatic step(input logic [c_NUM_CH-1:0] exp_gnt, input bit push_en, input string name);
        int   a;
        exp_t e;
        #1;
        checks++;
        if (rd_gnt !== exp_gnt) begin
            errors++;
            $display("FAIL %s rd_gnt got %h want %h", name, rd_gnt, exp_gnt);
        end
        #2;
        if (push_en) begin
            for (int c = 0; c < c_NUM_CH; c++) begin
                if (exp_gnt[c]) begin
                    a      = int'(rd_addr[c*c_ADDR_W +: c_ADDR_W]);
                    e.ch   = c;
                    e.err  = (a >= c_DEPTH) || (a == parity_bad);
                    e.data = (a >= c_DEPTH) ? 32'h0 : (model.exists(a) ? model[a] : 32'h0);
                    exp_q.push_back(e);
                end
            end
        end
        if (wr_en && int'(wr_addr) < c_DEPTH) model[int'(wr_addr)] = wr_data;
        @(negedge clock_mem);
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = c_ADDR_W'(addr);
        wr_data = data;
        step('0, 1'b1, "write");
        wr_en   = 1'b0;
    endtask

    // Monitor: sample mid-cycle after the stimulus edge.
    initial begin
        logic [c_NUM_CH*c_DATA_W-1:0] exp_data;
        logic [c_NUM_CH-1:0]          exp_err;
        exp_t                         e;
        for (int c = 0; c < c_NUM_CH; c++) last_data[c] = '0;
        forever begin
            @(negedge clock_mem);
            #2;
            if (rst) begin
                checks++;
                if (rd_valid !== '0 || rd_data !== '0 || rd_err !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs valid %h err %h data_nonzero %0d want all 0",
                             rd_valid, rd_err, (rd_data !== '0));
                end
                for (int c = 0; c < c_NUM_CH; c++) last_data[c] = '0;
            end else begin
                exp_err = '0;
                for (int c = 0; c < c_NUM_CH; c++) begin
                    if (rd_valid[c]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_valid ch %0d got valid want none", c);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.ch != c || rd_data[c*c_DATA_W +: c_DATA_W] !== e.data || rd_err[c] !== e.err) begin
                                errors++;
                                $display("FAIL read_resp ch %0d data %h err %b want ch %0d data %h err %b",
                                         c, rd_data[c*c_DATA_W +: c_DATA_W], rd_err[c], e.ch, e.data, e.err);
                            end
                            last_data[c] = e.data;
                            exp_err[c]   = e.err;
                        end
                    end
                end
                for (int c = 0; c < c_NUM_CH; c++) exp_data[c*c_DATA_W +: c_DATA_W] = last_data[c];
                checks++;
                if (rd_data !== exp_data || rd_err !== exp_err) begin
                    errors++;
                    $display("FAIL data_hold data %h err %h want data %h err %h", rd_data, rd_err, exp_data, exp_err);
                end
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_valid pending %0d want 0 (first ch %0d)", exp_q.size(), exp_q[0].ch);
                exp_q.delete();
            end
        end
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = '0;
        rd_addr = '0;
        rd(0, 5);
        @(negedge clock_mem);
        step('0, 1'b1, "gnt_in_reset_a");
        step('0, 1'b1, "gnt_in_reset_b");
        rst    = 1'b0;
        rd_req = '0;

        // Preload
        wr(5, 32'hDEADBEEF);
        rd(0, 5);                       step(21'h000001, 1'b1, "single_read");
        rd_req = '0;
        wr(0, 32'hA0); wr(1, 32'hA1); wr(2, 32'hA2); wr(3, 32'hA3);
        wr(4, 32'hB4); wr(8, 32'hB8); wr(12, 32'hBC);
        wr(16, 32'hC0); wr(20, 32'hC4); wr(7, 32'h22); wr(6, 32'h06);
        wr(10, 32'h10); wr(13, 32'h13); wr(9, 32'h99);

        // Four different banks in parallel
        rd(0, 0); rd(1, 1); rd(2, 2); rd(3, 3);
        step(21'h00000F, 1'b1, "four_banks");
        rd_req = '0;

        // Same-bank contention, round-robin order 1,2,3
        rd(1, 4); rd(2, 8); rd(3, 12);  step(21'h000002, 1'b1, "rr_first");
        rd_req[1] = 1'b0;               step(21'h000004, 1'b1, "rr_second");
        rd_req[2] = 1'b0;               step(21'h000008, 1'b1, "rr_third");
        rd_req = '0;

        // Pointer at 4: channel 5 beats channel 0
        rd(0, 16); rd(5, 20);           step(21'h000020, 1'b1, "rr_ptr_after");
        rd_req[5] = 1'b0;               step(21'h000001, 1'b1, "rr_wrap");
        rd_req = '0;

        // Write and read same address: read stalls, then sees the new data
        wr_en = 1'b1; wr_addr = 16'd7; wr_data = 32'h11;
        rd(5, 7);                       step('0, 1'b1, "rw_same_addr_stall");
        wr_en = 1'b0;                   step(21'h000020, 1'b1, "rw_same_addr_retry");
        rd_req = '0;

        // Write to a different address of the same bank also blocks the read
        wr_en = 1'b1; wr_addr = 16'd14; wr_data = 32'h0E;
        rd(4, 10);                      step('0, 1'b1, "bank_write_block");
        wr_en = 1'b0;                   step(21'h000010, 1'b1, "bank_write_retry");
        rd_req = '0;

        // Out-of-range reads granted at once alongside normal bank reads
        rd(2, 40000); rd(6, 6); rd(7, 1); rd(10, 50000);
        step(21'h0004C4, 1'b1, "oor_read_mix");
        rd_req = '0;

        // Out-of-range write takes no bank
        wr_en = 1'b1; wr_addr = 16'd40001; wr_data = 32'hBAD0BAD0;
        rd(8, 13);                      step(21'h000100, 1'b1, "oor_write_no_block");
        wr_en = 1'b0; rd_req = '0;

        // Reset right after acceptance: the response is dropped
        rd(4, 5);                       step(21'h000010, 1'b0, "accept_before_rst");
        rd_req = '0; rst = 1'b1;        step('0, 1'b0, "rst_a");
        rd(4, 5);                       step('0, 1'b0, "rst_gnt_zero");
        rd_req = '0;                    step('0, 1'b0, "rst_b");
        rst = 1'b0;

        // Pointers back at 0: channel 0 wins over channel 1 on bank 0
        rd(0, 0); rd(1, 4);             step(21'h000001, 1'b1, "ptr_reset");
        rd_req[0] = 1'b0;               step(21'h000002, 1'b1, "ptr_reset_next");
        rd_req = '0;

        // Memory survives reset
        rd(3, 5);                       step(21'h000008, 1'b1, "mem_kept");
        rd_req = '0;

`ifdef NN_MEM_PARITY_EN
        // Corrupt the stored parity of addr 9 (bank 1, row 2)
        dut.g_bank[1].r_mem[2][c_DATA_W] = ~dut.g_bank[1].r_mem[2][c_DATA_W];
        parity_bad = 9;
        rd(9, 9);                       step(21'h000200, 1'b1, "parity_err");
        rd_req = '0;
`endif

        step('0, 1'b1, "idle_a");
        step('0, 1'b1, "idle_b");
        step('0, 1'b1, "idle_c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
